// File: rtl/alu_pkg.sv
// Opcode and ALU-op encodings shared by the execute-stage ALU wrapper.
// The divider is built only when ALU_DIV_EN is defined.
package alu_pkg;

  typedef logic [4:0] opcode_t;

  typedef enum logic [2:0] {
    ADDA = 3'b000,
    SUBA = 3'b001,
    MULA = 3'b010,
    DIVA = 3'b011,
    ANDA = 3'b100,
    ORA  = 3'b101,
    XORA = 3'b110,
    NOTA = 3'b111
  } alu_op_t;

  localparam opcode_t ADD   = 5'b00010;
  localparam opcode_t ADDI  = 5'b00011;
  localparam opcode_t SUB   = 5'b00100;
  localparam opcode_t SUBI  = 5'b00101;
  localparam opcode_t MUL   = 5'b00110;
  localparam opcode_t MOVEH = 5'b00111;
  localparam opcode_t DIV   = 5'b01000;
  localparam opcode_t AND   = 5'b01010;
  localparam opcode_t ANDI  = 5'b01011;
  localparam opcode_t OR    = 5'b01100;
  localparam opcode_t ORI   = 5'b01101;
  localparam opcode_t NOT   = 5'b01110;
  localparam opcode_t XOR   = 5'b10000;
  localparam opcode_t XORI  = 5'b10001;
  localparam opcode_t CMP   = 5'b10010;
  localparam opcode_t ST    = 5'b11100;
  localparam opcode_t LD    = 5'b11101;
  localparam opcode_t MOVEL = 5'b11110;

endpackage

// File: rtl/alu_wrapper_top_alu.sv
// Combinational 32-bit ALU core; the divider exists only when ALU_DIV_EN is defined,
// otherwise DIV yields zero.
module alu
  import alu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (op)
      ADDA: result = in1 + in2;
      SUBA: result = in1 - in2;
      MULA: result = in1 * in2;
      DIVA: begin
`ifdef ALU_DIV_EN
        if (in2 == 32'd0) begin
          result = 32'hFFFF_FFFF;
        end else begin
          result = in1 / in2;
        end
`else
        result = 32'd0;
`endif
      end
      ANDA: result = in1 & in2;
      ORA:  result = in1 | in2;
      XORA: result = in1 ^ in2;
      NOTA: result = (in1 == 32'd0) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_wrapper_top.sv
// Execute-stage ALU wrapper: opcode decode, operand select and the {Z,N} flags register.
// DIV support depends on ALU_DIV_EN (see alu).
module alu_wrapper_top
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm,
  input  logic [4:0]  opcode,
  output logic [31:0] out,
  output logic [1:0]  flags
);

  alu_op_t     alu_op_s;
  logic        use_imm_s;
  logic        set_flags_s;
  logic [31:0] op2_s;
  logic [31:0] diff_s;
  logic        ovf_s;
  logic [1:0]  flags_d;
  logic [1:0]  flags_q;

  always_comb begin
    alu_op_s    = ADDA;
    use_imm_s   = 1'b0;
    set_flags_s = 1'b0;
    case (opcode)
      ADD:   alu_op_s = ADDA;
      ADDI:  begin alu_op_s = ADDA; use_imm_s = 1'b1; end
      LD:    begin alu_op_s = ADDA; use_imm_s = 1'b1; end
      ST:    begin alu_op_s = ADDA; use_imm_s = 1'b1; end
      SUB:   begin alu_op_s = SUBA; set_flags_s = 1'b1; end
      SUBI:  begin alu_op_s = SUBA; use_imm_s = 1'b1; set_flags_s = 1'b1; end
      CMP:   begin alu_op_s = SUBA; set_flags_s = 1'b1; end
      MUL:   alu_op_s = MULA;
      DIV:   alu_op_s = DIVA;
      AND:   alu_op_s = ANDA;
      ANDI:  begin alu_op_s = ANDA; use_imm_s = 1'b1; end
      MOVEH: begin alu_op_s = ANDA; use_imm_s = 1'b1; end
      MOVEL: begin alu_op_s = ANDA; use_imm_s = 1'b1; end
      OR:    alu_op_s = ORA;
      ORI:   begin alu_op_s = ORA; use_imm_s = 1'b1; end
      XOR:   alu_op_s = XORA;
      XORI:  begin alu_op_s = XORA; use_imm_s = 1'b1; end
      NOT:   alu_op_s = NOTA;
      default: alu_op_s = ADDA;
    endcase
  end

  assign op2_s = use_imm_s ? imm : b;

  alu ALU (
    .op     (alu_op_s),
    .in1    (a),
    .in2    (op2_s),
    .result (out)
  );

  // N is the true signed less-than: result sign corrected by signed overflow.
  always_comb begin
    diff_s = a - op2_s;
    ovf_s  = (a[31] ^ op2_s[31]) & (a[31] ^ diff_s[31]);
    if (set_flags_s) begin
      flags_d = {(a == op2_s), (diff_s[31] ^ ovf_s)};
    end else begin
      flags_d = flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_wrapper_top.sv
// Directed self-checking bench for alu_wrapper_top; DIV expectations follow ALU_DIV_EN.
module tb_alu_wrapper_top;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm;
  logic [4:0]  opcode;
  logic [31:0] out;
  logic [1:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  alu_wrapper_top dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .imm    (imm),
    .opcode (opcode),
    .out    (out),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vi);
    opcode = op;
    a      = va;
    b      = vb;
    imm    = vi;
    #1;
  endtask

  logic [4:0] sweep_opc [19] = '{ADD, ADDI, LD, ST, SUB, SUBI, CMP, MUL, DIV, AND, ANDI,
                                 MOVEH, MOVEL, OR, ORI, XOR, XORI, NOT, 5'b00000};
  logic [2:0] sweep_op  [19] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                                 3'b010, 3'b011, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101,
                                 3'b101, 3'b110, 3'b110, 3'b111, 3'b000};
  logic [31:0] div_exp;
  logic [31:0] div0_exp;

  initial begin
    rst = 1'b1;
    drive(CMP, 32'd3, 32'd3, 32'd0);
    @(negedge clk);
    check("flags_reset", {30'd0, flags}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(sweep_opc[i], 32'd0, 32'd0, 32'd0);
      check($sformatf("decode_%05b", sweep_opc[i]), {29'd0, dut.ALU.op}, {29'd0, sweep_op[i]});
    end

`ifdef ALU_DIV_EN
    div_exp  = 32'd14;
    div0_exp = 32'hFFFF_FFFF;
`else
    div_exp  = 32'd0;
    div0_exp = 32'd0;
`endif

    drive(ADD,   32'hFFFF_FFFF, 32'd1,          32'd55);          check("add_wrap", out, 32'd0);
    drive(SUBI,  32'd5,         32'd99,         32'd7);           check("subi_neg", out, 32'hFFFF_FFFE);
    drive(MUL,   32'h0001_0000, 32'h0001_0000,  32'd0);           check("mul_trunc", out, 32'd0);
    drive(MUL,   32'd1234,      32'd1000,       32'd0);           check("mul_small", out, 32'd1234000);
    drive(DIV,   32'd100,       32'd7,          32'd0);           check("div", out, div_exp);
    drive(DIV,   32'd100,       32'd0,          32'd0);           check("div_by0", out, div0_exp);
    drive(NOT,   32'd0,         32'd5,          32'd0);           check("not_zero", out, 32'd1);
    drive(NOT,   32'h8000_0000, 32'd0,          32'd0);           check("not_nz", out, 32'd0);
    drive(XORI,  32'hF0F0_F0F0, 32'd0,          32'hFFFF_0000);   check("xori", out, 32'h0F0F_F0F0);
    drive(ADDI,  32'd10,        32'd99,         32'd20);          check("addi", out, 32'd30);
    drive(AND,   32'h0000_F0F0, 32'h0000_FF00,  32'hFFFF_FFFF);   check("and_reg", out, 32'h0000_F000);
    drive(ORI,   32'd1,         32'd8,          32'd2);           check("ori", out, 32'd3);
    drive(MOVEL, 32'h1234_5678, 32'd0,          32'h0000_FFFF);   check("movel", out, 32'h0000_5678);
    drive(LD,    32'd100,       32'd50,         32'd8);           check("ld_addr", out, 32'd108);
    drive(SUB,   32'd10,        32'd3,          32'd1);           check("sub_reg", out, 32'd7);
    drive(XOR,   32'hAAAA_5555, 32'hFFFF_FFFF,  32'd0);           check("xor_reg", out, 32'h5555_AAAA);

    // Flags sequence; reset released with CMP 3,3 already presented.
    drive(CMP, 32'd3, 32'd3, 32'd0);
    check("out_in_reset", out, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("flags_eq", {30'd0, flags}, 32'b10);

    @(negedge clk); drive(CMP, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(posedge clk); #1;
    check("flags_lt", {30'd0, flags}, 32'b01);

    @(negedge clk); drive(ADD, 32'd7, 32'd7, 32'd0);
    @(posedge clk); #1;
    check("flags_hold_add", {30'd0, flags}, 32'b01);

    @(negedge clk); drive(SUBI, 32'd9, 32'd1, 32'd9);
    @(posedge clk); #1;
    check("flags_subi_eq", {30'd0, flags}, 32'b10);

    @(negedge clk); drive(CMP, 32'h8000_0000, 32'd1, 32'd0);
    @(posedge clk); #1;
    check("flags_ovf_lt", {30'd0, flags}, 32'b01);

    @(negedge clk); drive(CMP, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1;
    check("flags_ovf_gt", {30'd0, flags}, 32'b00);

    @(negedge clk); drive(SUB, 32'd2, 32'd5, 32'd2);
    @(posedge clk); #1;
    check("flags_sub_lt", {30'd0, flags}, 32'b01);

    @(negedge clk); drive(CMP, 32'd4, 32'd4, 32'd0);
    @(posedge clk); #1;
    check("flags_before_rst", {30'd0, flags}, 32'b10);
    #1;
    rst = 1'b1;
    #1;
    check("flags_async_rst", {30'd0, flags}, 32'b00);
    @(posedge clk); #1;
    check("flags_rst_held", {30'd0, flags}, 32'b00);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
